fetch_queue_stage: RTL and testbench

- Parametrised successor to the single-entry fetch_stage.
- Issues in-order instruction fetches to a handshaked instruction memory port with variable latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode through a valid/ready handshake. This replaces the old stall input.
- A taken branch from EX flushes the queue, discards in-flight responses and redirects fetch.

---
 rtl/fetch_queue_stage.sv | 107 ++++++++++
 tb/tb_fetch_queue_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Fetch stage that issues credit-limited requests to a variable-latency
// instruction memory and queues returned words for decode.
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        ex_if_take_branch,
  input  logic [31:0] ex_if_branch_target,
  output logic        if_id_valid,
  input  logic        id_if_ready,
  output logic [31:0] if_id_instr_data,
  output logic [31:0] if_id_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        q [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   target;
  logic [CW:0]   credit_used;
  logic          flush;
  logic          fire;
  logic          dropping;
  logic          enq;
  logic          deq;

  assign flush       = ex_if_take_branch;
  assign target      = ex_if_branch_target & 32'hFFFF_FFFC;
  assign credit_used = {1'b0, count} + {1'b0, outstanding};

  assign imem_req_valid = rst_n && !flush && (credit_used < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign dropping = drop_cnt != '0;
  assign enq      = imem_rsp_valid && !dropping && !flush;

  assign if_id_valid      = count != '0;
  assign deq              = if_id_valid && id_if_ready && !flush;
  assign if_id_instr_data = if_id_valid ? q[rd_ptr].instr : NOP_INSTR;
  assign if_id_pc         = if_id_valid ? q[rd_ptr].pc : rsp_pc;

  // outstanding counts every in-flight request, including those
  // already marked for dropping, so a flush never double-counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire)
                   - CW'(imem_rsp_valid);
      if (flush) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (enq) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        if (enq && !deq) count <= count + CW'(1);
        else if (!enq && deq) count <= count - CW'(1);
        if (imem_rsp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) q[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) enq |-> (count != FULL)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with an in-order
// variable-latency memory model; memory word at addr is ~addr.
module tb_fetch_queue_stage;
  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ex_if_take_branch;
  logic [31:0] ex_if_branch_target;
  logic        if_id_valid;
  logic        id_if_ready;
  logic [31:0] if_id_instr_data;
  logic [31:0] if_id_pc;

  fetch_queue_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .ex_if_take_branch  (ex_if_take_branch),
    .ex_if_branch_target(ex_if_branch_target),
    .if_id_valid        (if_id_valid),
    .id_if_ready        (id_if_ready),
    .if_id_instr_data   (if_id_instr_data),
    .if_id_pc           (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          fires = 0;
  bit          toggle = 0;
  logic        s_req_valid, s_req_ready, s_fire, s_rsp, s_valid;
  logic [31:0] s_req_addr, s_pc, s_instr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge, then advance the memory model
  // just after the rising edge.
  task automatic step();
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_req_ready = imem_req_ready;
    s_valid     = if_id_valid;
    s_pc        = if_id_pc;
    s_instr     = if_id_instr_data;
    s_rsp       = imem_rsp_valid;
    s_fire      = s_req_valid && s_req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (s_fire) fires++;
    if (s_rsp && pq.size() > 0) pq.delete(0);
    if (s_fire) pq.push_back('{s_req_addr, cyc + lat - 1});
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ~pq[0].addr;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (toggle) imem_req_ready = !imem_req_ready;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = s_valid;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pq.delete();
    imem_rsp_valid    = 1'b0;
    imem_rsp_data     = '0;
    ex_if_take_branch = 1'b0;
    imem_req_ready    = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fires = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          ok;
    bit          pend;
    logic [31:0] paddr, exp, exp_req;

    rst_n               = 1'b0;
    imem_req_ready      = 1'b1;
    imem_rsp_valid      = 1'b0;
    imem_rsp_data       = '0;
    ex_if_take_branch   = 1'b0;
    ex_if_branch_target = '0;
    id_if_ready         = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_if_valid", 32'(if_id_valid), 0);
    chk("rst_instr", if_id_instr_data, 32'h13);
    chk("rst_pc", if_id_pc, 32'h0);

    // Streaming with 1-cycle memory
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        chk("t1_req_valid", 32'(s_req_valid), 1);
        chk("t1_req_addr", s_req_addr, 32'h0);
      end else if (i == 1) begin
        chk("t1_pre_valid", 32'(s_valid), 0);
        chk("t1_pre_instr", s_instr, 32'h13);
      end else begin
        chk("t1_valid", 32'(s_valid), 1);
        chk("t1_pc", s_pc, 32'(4 * (i - 2)));
        chk("t1_instr", s_instr, ~32'(4 * (i - 2)));
      end
    end

    // Decode stalled: queue fills, requests stop
    id_if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("t2_fires", 32'(fires), 4);
    chk("t2_req_valid", 32'(s_req_valid), 0);
    chk("t2_head_valid", 32'(s_valid), 1);
    chk("t2_head_pc", s_pc, 32'h0);
    id_if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(4, ok);
      chk("t2_seen", 32'(ok), 1);
      chk("t2_pc", s_pc, 32'(4 * i));
      chk("t2_instr", s_instr, ~32'(4 * i));
    end

    // Latency 3 with a toggling request ready
    lat = 3;
    do_reset();
    toggle  = 1'b1;
    pend    = 1'b0;
    paddr   = '0;
    exp     = '0;
    exp_req = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pend) begin
        chk("t3_hold_valid", 32'(s_req_valid), 1);
        chk("t3_hold_addr", s_req_addr, paddr);
      end
      pend  = s_req_valid && !s_req_ready;
      paddr = s_req_addr;
      if (s_fire) begin
        chk("t3_req_addr", s_req_addr, exp_req);
        exp_req += 4;
      end
      if (s_valid) begin
        chk("t3_pc", s_pc, exp);
        chk("t3_instr", s_instr, ~exp);
        exp += 4;
      end
    end
    chk("t3_progress", 32'(exp >= 32'h20), 1);
    toggle = 1'b0;

    // Branch with 3 in flight and a response in the flush cycle
    do_reset();
    for (int i = 0; i < 3; i++) step();
    ex_if_take_branch   = 1'b1;
    ex_if_branch_target = 32'hA0;
    step();
    chk("t4_flush_req", 32'(s_req_valid), 0);
    ex_if_take_branch = 1'b0;
    step();
    chk("t4_req_addr", s_req_addr, 32'hA0);
    wait_valid(12, ok);
    chk("t4_seen0", 32'(ok), 1);
    chk("t4_pc0", s_pc, 32'hA0);
    chk("t4_instr0", s_instr, ~32'hA0);
    wait_valid(6, ok);
    chk("t4_seen1", 32'(ok), 1);
    chk("t4_pc1", s_pc, 32'hA4);

    // Misaligned target
    lat = 1;
    do_reset();
    step();
    ex_if_take_branch   = 1'b1;
    ex_if_branch_target = 32'hA3;
    step();
    ex_if_take_branch = 1'b0;
    step();
    chk("t5_req_addr", s_req_addr, 32'hA0);
    wait_valid(8, ok);
    chk("t5_seen", 32'(ok), 1);
    chk("t5_pc", s_pc, 32'hA0);

    // Back-to-back flushes
    lat = 3;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    ex_if_take_branch   = 1'b1;
    ex_if_branch_target = 32'h40;
    step();
    ex_if_branch_target = 32'h80;
    step();
    ex_if_take_branch = 1'b0;
    step();
    chk("t6_req_addr", s_req_addr, 32'h80);
    wait_valid(12, ok);
    chk("t6_seen", 32'(ok), 1);
    chk("t6_pc", s_pc, 32'h80);
    chk("t6_instr", s_instr, ~32'h80);

    // Asynchronous reset mid-burst
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_req_valid", 32'(imem_req_valid), 0);
    chk("t7_if_valid", 32'(if_id_valid), 0);
    chk("t7_instr", if_id_instr_data, 32'h13);
    chk("t7_pc", if_id_pc, 32'h0);
    pq.delete();
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("t7_restart_addr", s_req_addr, 32'h0);
    wait_valid(6, ok);
    chk("t7_seen", 32'(ok), 1);
    chk("t7_first_pc", s_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
